simon32s64_key_sched: RTL and testbench
=======================================

// Module: simon32s64_key_sched
// PURPOSE
//  Simon32/64 key-schedule expander, directly upstream of the encryption round engine.
//  Accepts one 64-bit master key and streams the 32 16-bit round keys rk0..rk31 in order.
//  Emits one key per cycle under valid/ready flow control.
//  The encryptor consumes rk[i] in round i; the two blocks share no state beyond this stream.
// PARAMETERS
//  none (all sizes are fixed by Simon32/64 and held as constants in simon_pkg)
// PORTS
//  clk             in   1   single clock; all logic on posedge
//  rst             in   1   asynchronous, active-low reset (asserted when 0)
//  enc_key_in      in  64   master key; [15:0]=k0, [31:16]=k1, [47:32]=k2, [63:48]=k3
//  enc_key_in_vld  in   1   key valid
//  enc_key_in_rdy  out  1   key accepted when vld&rdy
//  rk_out          out 16   current round key
//  rk_out_vld      out  1   rk_out valid
//  rk_out_rdy      in   1   consumer ready; transfer on vld&rdy
//  rk_idx          out  5   round index of rk_out (0..31)
//  rk_last         out  1   high with rk_idx==31
//  rk_replay       in   1   present only with SIMON_KS_REPLAY_EN; restart stream from cache
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, enc_key_in_rdy=0 until first clk after release.
//    rk_out=0, rk_out_vld=0, rk_idx=0, rk_last=0, word regs=0, cache-valid=0.
//  FSM IDLE: enc_key_in_rdy=1, rk_out_vld=0.
//    On key handshake: load w[0..3]=k0..k3, idx=0, go RUN.
//  FSM RUN: enc_key_in_rdy=0, rk_out_vld=1, rk_out=w[0], rk_idx=idx.
//  Latency: key handshake in cycle N -> rk0 valid in cycle N+1.
//    Full throughput is one key per cycle while rk_out_rdy=1.
//  Handshake: while vld&!rdy, rk_out/rk_idx/rk_last are held stable.
//    vld never drops before the transfer.
//  On each transfer: w[0..2]<=w[1..3], w[3]<=f(w,idx), idx<=idx+1.
//    f: t=ror3(w[3])^w[1]; t=t^ror1(t); f=16'hFFFC^Z0[idx]^w[0]^t (16-bit, no carry).
//    Z0 bit used for rk[i+4] is Z0[i], i=idx, i=0..27.
//    New words computed after idx>=28 are unused; no Z0 index beyond 27 is required.
//  Transfer with rk_last=1: go IDLE. enc_key_in_rdy rises the next cycle.
//    A new key cannot load in the same cycle as the last transfer.
//  A key offered during RUN is not accepted; it waits (rdy=0) and is not dropped.
//  idx is 5 bits; it never wraps inside a stream because RUN exits at 31.
//  Reset asserted mid-stream: immediate abort to reset state.
//    The partial stream is discarded; the consumer must also be reset.
// CONFIGURATION
//  SIMON_KS_REPLAY_EN defined:
//    32x16 register cache filled with rk0..rk31 during RUN; cache-valid set after rk31.
//    rk_replay=1 in IDLE with cache-valid=1 -> FSM REPLAY.
//    REPLAY streams cache[0..31] with identical handshake, latency, rk_idx and rk_last rules.
//    rk_replay with cache-valid=0 is ignored.
//    If rk_replay and enc_key_in_vld are both high in IDLE, the new key wins and the cache is invalidated.
//  SIMON_KS_REPLAY_EN undefined: no rk_replay port, no cache, no REPLAY state.
// STRUCTURE
//  simon_pkg: SIMON_C=16'hFFFC, SIMON_Z0 (62-bit z0 sequence, bit 0 first = 1),
//    SIMON_ROUNDS=32, SIMON_WORD=16, typedef logic [15:0] simon_word_t,
//    ks_state_e {IDLE,RUN,REPLAY}.
//    The encryptor shares this package.
//  Sub-module: simon32s64_ks_round, combinational f(w0,w1,w3,zbit).
//  Top: FSM, counter, word shift register, optional cache.
// TESTING
//  1. Key 64'h1918_1110_0908_0100, rk_out_rdy=1 ->
//     rk0..rk4 = 0100,0908,1110,1918,71C3 on consecutive cycles.
//     32 keys total; rk_last only on idx 31; then IDLE.
//  2. Same key, rk_out_rdy toggled randomly -> identical 32-key sequence.
//     Outputs stable on every vld&!rdy cycle; no key dropped or duplicated.
//  3. Second key asserted from mid-stream -> held (rdy=0).
//     Accepted on the first IDLE cycle; second stream starts with its own k0.
//  4. rst driven low at idx=10 asynchronously -> vld=0, idx=0 with no clock edge.
//     After release, a fresh key yields a correct full stream.
//  5. Chained with the encryptor, key above, plaintext 32'h6565_6877 ->
//     ciphertext 32'hC69B_E9BB.
//  6. SIMON_KS_REPLAY_EN: stream once, then pulse rk_replay -> identical 32 keys.
//     rk_replay before any key -> no output. Simultaneous new key + replay -> new schedule.

Source files
------------

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - Simon32/64 constants and types shared by key schedule and encryptor
package simon_pkg;

  localparam int SIMON_WORD   = 16;
  localparam int SIMON_ROUNDS = 32;

  typedef logic [SIMON_WORD-1:0] simon_word_t;

  localparam simon_word_t SIMON_C = 16'hFFFC;

  // z0 sequence, bit 0 is the first element of the published sequence
  localparam logic [61:0] SIMON_Z0 =
    62'b0110011100001101010010001011111_0110011100001101010010001011111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPLAY
  } ks_state_e;

endpackage

// File: rtl/simon32s64_key_sched_if.sv
// rtl/simon32s64_key_sched_if.sv - master key in / round key out streams (rk_replay with SIMON_KS_REPLAY_EN)
interface simon32s64_key_sched_if;
  import simon_pkg::*;

  logic [63:0] enc_key_in;
  logic        enc_key_in_vld;
  logic        enc_key_in_rdy;
  simon_word_t rk_out;
  logic        rk_out_vld;
  logic        rk_out_rdy;
  logic [4:0]  rk_idx;
  logic        rk_last;
`ifdef SIMON_KS_REPLAY_EN
  logic        rk_replay;
`endif

  modport slave (
    input  enc_key_in, enc_key_in_vld, rk_out_rdy,
`ifdef SIMON_KS_REPLAY_EN
    input  rk_replay,
`endif
    output enc_key_in_rdy, rk_out, rk_out_vld, rk_idx, rk_last
  );

  modport master (
    output enc_key_in, enc_key_in_vld, rk_out_rdy,
`ifdef SIMON_KS_REPLAY_EN
    output rk_replay,
`endif
    input  enc_key_in_rdy, rk_out, rk_out_vld, rk_idx, rk_last
  );

endinterface

// File: rtl/simon32s64_ks_round.sv
// rtl/simon32s64_ks_round.sv - one key expansion step: next word from w0, w1, w3 and a z0 bit
module simon32s64_ks_round
  import simon_pkg::*;
(
  input  simon_word_t w0,
  input  simon_word_t w1,
  input  simon_word_t w3,
  input  logic        zbit,
  output simon_word_t w_new
);

  simon_word_t t0;
  simon_word_t t1;

  assign t0    = {w3[2:0], w3[15:3]} ^ w1;
  assign t1    = t0 ^ {t0[0], t0[15:1]};
  assign w_new = SIMON_C ^ {15'd0, zbit} ^ w0 ^ t1;

endmodule

// File: rtl/simon32s64_key_sched.sv
// rtl/simon32s64_key_sched.sv - Simon32/64 key schedule streaming rk0..rk31; SIMON_KS_REPLAY_EN adds a replay cache
module simon32s64_key_sched
  import simon_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  simon32s64_key_sched_if.slave  ks
);

  ks_state_e   state;
  ks_state_e   state_nxt;
  simon_word_t w [4];
  simon_word_t w_new;
  logic [4:0]  idx;
  logic        armed;
  logic        key_hs;
  logic        rk_hs;
  logic        last;
  logic        replay_go;

  assign key_hs = ks.enc_key_in_vld && ks.enc_key_in_rdy;
  assign rk_hs  = ks.rk_out_vld && ks.rk_out_rdy;
  assign last   = (idx == 5'(SIMON_ROUNDS - 1));

  // armed keeps the key port closed until the first clock after reset release
  assign ks.enc_key_in_rdy = armed && (state == IDLE);
  assign ks.rk_out_vld     = (state != IDLE);
  assign ks.rk_idx         = idx;
  assign ks.rk_last        = ks.rk_out_vld && last;

  simon32s64_ks_round u_round (
    .w0    (w[0]),
    .w1    (w[1]),
    .w3    (w[3]),
    .zbit  (SIMON_Z0[idx]),
    .w_new (w_new)
  );

`ifdef SIMON_KS_REPLAY_EN
  simon_word_t cache [SIMON_ROUNDS];
  logic        cache_vld;

  assign replay_go = (state == IDLE) && armed && ks.rk_replay && cache_vld && !key_hs;
  assign ks.rk_out = (state == REPLAY) ? cache[idx] : w[0];

  always_ff @(posedge clk) begin
    if (state == RUN && rk_hs) begin
      cache[idx] <= w[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld <= 1'b0;
    end else if (key_hs) begin
      cache_vld <= 1'b0;
    end else if (state == RUN && rk_hs && last) begin
      cache_vld <= 1'b1;
    end
  end
`else
  assign replay_go = 1'b0;
  assign ks.rk_out = w[0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_hs) begin
          state_nxt = RUN;
        end else if (replay_go) begin
          state_nxt = REPLAY;
        end
      end
      RUN, REPLAY: begin
        if (rk_hs && last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx wraps 31->0 on the last transfer, which leaves it at 0 for the next stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
      idx   <= 5'd0;
      w[0]  <= '0;
      w[1]  <= '0;
      w[2]  <= '0;
      w[3]  <= '0;
    end else begin
      armed <= 1'b1;
      if (key_hs) begin
        idx  <= 5'd0;
        w[0] <= ks.enc_key_in[15:0];
        w[1] <= ks.enc_key_in[31:16];
        w[2] <= ks.enc_key_in[47:32];
        w[3] <= ks.enc_key_in[63:48];
      end else if (replay_go) begin
        idx <= 5'd0;
      end else if (rk_hs) begin
        idx <= idx + 5'd1;
        if (state == RUN) begin
          w[0] <= w[1];
          w[1] <= w[2];
          w[2] <= w[3];
          w[3] <= w_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_simon32s64_key_sched.sv
// tb/tb_simon32s64_key_sched.sv - self-checking bench for simon32s64_key_sched (replay tests with SIMON_KS_REPLAY_EN)
module tb_simon32s64_key_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simon32s64_key_sched_if bus ();

  simon32s64_key_sched dut (
    .clk (clk),
    .rst (rst),
    .ks  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] got    [32];
  logic [15:0] exp_rk [32];

  string z0_s = "11111010001001010110000111001101111101000100101011000011100110";

  typedef struct {
    logic [63:0]      key;
    int               pct;
    bit               has_exp;
    logic [4:0][15:0] exp5;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  task automatic model_ks(input logic [63:0] key);
    logic [15:0] k [32];
    logic [15:0] tmp;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      tmp = ror16(k[i+3], 3) ^ k[i+1];
      tmp = tmp ^ ror16(tmp, 1);
      k[i+4] = ~k[i] ^ tmp ^ 16'(z0_s[i] == "1") ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) exp_rk[i] = k[i];
  endtask

  function automatic logic [31:0] encrypt(input logic [31:0] pt);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ got[r];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic offer_key(input logic [63:0] key);
    int n;
    n = 0;
    @(negedge clk);
    bus.enc_key_in     = key;
    bus.enc_key_in_vld = 1'b1;
    while (!bus.enc_key_in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("key_rdy", bus.enc_key_in_rdy, 1);
    @(posedge clk);
    #1;
    bus.enc_key_in_vld = 1'b0;
  endtask

  task automatic collect(input int pct, input bit inject, input logic [63:0] key2);
    int          n, cyc;
    bit          stall, hold_ok, idx_ok, last_ok, rdy_ok;
    logic [15:0] p_out;
    logic [4:0]  p_idx;
    logic        p_last;
    n = 0; cyc = 0; stall = 0;
    hold_ok = 1; idx_ok = 1; last_ok = 1; rdy_ok = 1;
    p_out = '0; p_idx = '0; p_last = 1'b0;
    while (n < 32 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      bus.rk_out_rdy = ($urandom_range(99) < pct);
      if (cyc == 1) chk("latency_vld", bus.rk_out_vld, 1);
      if (stall && (!bus.rk_out_vld || bus.rk_out !== p_out ||
                    bus.rk_idx !== p_idx || bus.rk_last !== p_last)) hold_ok = 0;
      if (inject && n >= 15) begin
        bus.enc_key_in     = key2;
        bus.enc_key_in_vld = 1'b1;
        if (bus.enc_key_in_rdy) rdy_ok = 0;
      end
      if (bus.rk_out_vld && bus.rk_out_rdy) begin
        got[n] = bus.rk_out;
        if (bus.rk_idx !== 5'(n)) idx_ok = 0;
        if (bus.rk_last !== (n == 31)) last_ok = 0;
        n++;
      end
      stall  = bus.rk_out_vld && !bus.rk_out_rdy;
      p_out  = bus.rk_out;
      p_idx  = bus.rk_idx;
      p_last = bus.rk_last;
    end
    chk("stream_count", n, 32);
    chk("stall_hold", hold_ok, 1);
    chk("rk_idx_seq", idx_ok, 1);
    chk("rk_last_pos", last_ok, 1);
    if (inject) chk("key_blocked_in_run", rdy_ok, 1);
    if (pct == 100) chk("throughput_cycles", cyc, 32);
    for (int i = 0; i < 32; i++) begin
      if (i < n) chk($sformatf("rk%0d", i), got[i], exp_rk[i]);
    end
    @(negedge clk);
    chk("idle_vld", bus.rk_out_vld, 0);
    chk("idle_key_rdy", bus.enc_key_in_rdy, 1);
    chk("idle_idx", bus.rk_idx, 0);
  endtask

  initial begin
    logic [63:0] k1, k2;
    int          n;
    bit          ok;

    bus.enc_key_in     = '0;
    bus.enc_key_in_vld = 1'b0;
    bus.rk_out_rdy     = 1'b0;
`ifdef SIMON_KS_REPLAY_EN
    bus.rk_replay      = 1'b0;
`endif

    rst = 1'b0;
    #3;
    chk("rst_vld", bus.rk_out_vld, 0);
    chk("rst_idx", bus.rk_idx, 0);
    chk("rst_last", bus.rk_last, 0);
    chk("rst_rk_out", bus.rk_out, 0);
    chk("rst_key_rdy", bus.enc_key_in_rdy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_key_rdy_low", bus.enc_key_in_rdy, 0);
    @(posedge clk);
    #1;
    chk("post_rst_key_rdy_high", bus.enc_key_in_rdy, 1);

`ifdef SIMON_KS_REPLAY_EN
    ok = 1;
    bus.rk_replay = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.rk_out_vld) ok = 0;
    end
    bus.rk_replay = 1'b0;
    chk("replay_without_cache", ok, 1);
`endif

    tbl[0] = '{key: 64'h1918_1110_0908_0100, pct: 100, has_exp: 1'b1,
               exp5: {16'h71C3, 16'h1918, 16'h1110, 16'h0908, 16'h0100}};
    tbl[1] = '{key: 64'h1918_1110_0908_0100, pct: 50, has_exp: 1'b1,
               exp5: {16'h71C3, 16'h1918, 16'h1110, 16'h0908, 16'h0100}};
    for (int i = 2; i < 6; i++) begin
      tbl[i] = '{key: {$urandom, $urandom}, pct: 30 + int'($urandom_range(60)),
                 has_exp: 1'b0, exp5: '0};
    end

    for (int v = 0; v < 6; v++) begin
      model_ks(tbl[v].key);
      offer_key(tbl[v].key);
      collect(tbl[v].pct, 1'b0, '0);
      if (tbl[v].has_exp) begin
        for (int j = 0; j < 5; j++) chk($sformatf("vec%0d_rk%0d", v, j), got[j], tbl[v].exp5[j]);
      end
      if (v == 0) chk("cipher", encrypt(32'h6565_6877), 32'hC69B_E9BB);
    end

    k1 = {$urandom, $urandom};
    k2 = {$urandom, $urandom};
    model_ks(k1);
    offer_key(k1);
    collect(70, 1'b1, k2);
    @(posedge clk);
    #1;
    bus.enc_key_in_vld = 1'b0;
    model_ks(k2);
    collect(70, 1'b0, '0);

    k1 = {$urandom, $urandom};
    model_ks(k1);
    offer_key(k1);
    bus.rk_out_rdy = 1'b1;
    n = 0;
    while (bus.rk_idx != 5'd10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx10", bus.rk_idx, 10);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_vld", bus.rk_out_vld, 0);
    chk("abort_idx", bus.rk_idx, 0);
    chk("abort_rk_out", bus.rk_out, 0);
    chk("abort_last", bus.rk_last, 0);
    chk("abort_key_rdy", bus.enc_key_in_rdy, 0);
    @(negedge clk);
    rst = 1'b1;
    k2 = {$urandom, $urandom};
    model_ks(k2);
    offer_key(k2);
    collect(80, 1'b0, '0);

`ifdef SIMON_KS_REPLAY_EN
    k1 = {$urandom, $urandom};
    model_ks(k1);
    offer_key(k1);
    collect(100, 1'b0, '0);
    @(negedge clk);
    bus.rk_replay = 1'b1;
    @(posedge clk);
    #1;
    bus.rk_replay = 1'b0;
    collect(60, 1'b0, '0);
    k2 = {$urandom, $urandom};
    @(negedge clk);
    bus.enc_key_in     = k2;
    bus.enc_key_in_vld = 1'b1;
    bus.rk_replay      = 1'b1;
    @(posedge clk);
    #1;
    bus.enc_key_in_vld = 1'b0;
    bus.rk_replay      = 1'b0;
    model_ks(k2);
    collect(60, 1'b0, '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
